// File: rtl/offchip_line_arbiter_pkg.sv
// Shared constants for the off-chip line arbiter: line geometry,
// FSM state encodings and requester ids.
package offchip_line_arbiter_pkg;

   // Bytes per cache line and top address bit of the core.
   localparam int CACHE_LINE_SIZE = 16;
   localparam int MAX_BIT_POS     = 31;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_e;

   // Requester ids; the value also indexes the {dc, ic} request vector.
   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } req_id_e;

endpackage

// File: rtl/offchip_line_arbiter_rr_arb2.sv
// Two-input round-robin grant. The grant is combinational from the request
// vector; the last-granted pointer advances only on the update strobe, so a
// tie always goes to the side that was not served last.
module rr_arb2
   import offchip_line_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   input  req_id_e    upd_id,
   output logic       gnt_vld,
   output req_id_e    gnt_id
);

   req_id_e last_gnt;

   // Remember who was served last; reset favours the D-cache on the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_gnt <= REQ_IC;
      else if (upd)
         last_gnt <= upd_id;
   end

   // D-cache wins when alone, or on a tie when the I-cache went last.
   always_comb begin
      gnt_vld = |req;
      gnt_id  = REQ_IC;
      if (req[1] && (!req[0] || last_gnt == REQ_IC))
         gnt_id = REQ_DC;
   end

endmodule

// File: rtl/offchip_line_arbiter.sv
// Off-chip line arbiter: serialises I-cache fills and D-cache fills/writebacks
// onto one whole-line port. Command, address and write data are latched at
// grant and held through BUSY; the DONE state forces a two-cycle enable gap
// so the downstream port can re-arm. A watchdog ends stalled transactions
// with an error.
module offchip_line_arbiter
   import offchip_line_arbiter_pkg::*;
#(
   parameter int LINE_BYTES = CACHE_LINE_SIZE,
   parameter int ADDR_W     = MAX_BIT_POS + 1,
   parameter int TIMEOUT    = 1024
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ic_req,
   input  logic [ADDR_W-1:0]       ic_addr,
   output logic                    ic_done,
   output logic [LINE_BYTES*8-1:0] ic_rdata,
   output logic                    ic_err,
   input  logic                    dc_req,
   input  logic                    dc_we,
   input  logic [ADDR_W-1:0]       dc_addr,
   input  logic [LINE_BYTES*8-1:0] dc_wdata,
   output logic                    dc_done,
   output logic [LINE_BYTES*8-1:0] dc_rdata,
   output logic                    dc_err,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_read_en,
   output logic                    mem_write_en,
   output logic [LINE_BYTES*8-1:0] mem_wdata,
   input  logic [LINE_BYTES*8-1:0] mem_rdata,
   input  logic                    mem_ready
);

   localparam int                WD_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);
   localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);
   localparam logic              WD_ON     = (TIMEOUT != 0);

   arb_state_e        state;
   req_id_e           gnt_q;
   logic [WD_W-1:0]   wdog;

   logic              gnt_vld;
   req_id_e           gnt_id;
   logic [ADDR_W-1:0] sel_addr;
   logic              wd_expired;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({dc_req, ic_req}),
      .upd     (state == ARB_DONE),
      .upd_id  (gnt_q),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   // Address of the side about to be granted, and the watchdog limit test.
   always_comb begin
      sel_addr   = (gnt_id == REQ_DC) ? dc_addr : ic_addr;
      wd_expired = WD_ON && (wdog == WD_LIMIT);
   end

   // Arbiter FSM with all port-facing outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ARB_IDLE;
         gnt_q        <= REQ_IC;
         wdog         <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         ic_done      <= 1'b0;
         ic_rdata     <= '0;
         ic_err       <= 1'b0;
         dc_done      <= 1'b0;
         dc_rdata     <= '0;
         dc_err       <= 1'b0;
      end else begin
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (gnt_vld) begin
                  gnt_q        <= gnt_id;
                  mem_addr     <= sel_addr & ~LINE_MASK;
                  mem_wdata    <= dc_wdata;
                  mem_read_en  <= (gnt_id == REQ_IC) || !dc_we;
                  mem_write_en <= (gnt_id == REQ_DC) && dc_we;
                  wdog         <= '0;
                  state        <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (mem_ready || wd_expired) begin
                  // A real completion wins over a simultaneous timeout.
                  if (mem_ready && mem_read_en) begin
                     if (gnt_q == REQ_DC)
                        dc_rdata <= mem_rdata;
                     else
                        ic_rdata <= mem_rdata;
                  end
                  if (gnt_q == REQ_DC) begin
                     dc_done <= 1'b1;
                     dc_err  <= !mem_ready;
                  end else begin
                     ic_done <= 1'b1;
                     ic_err  <= !mem_ready;
                  end
                  mem_read_en  <= 1'b0;
                  mem_write_en <= 1'b0;
                  state        <= ARB_DONE;
               end else if (WD_ON) begin
                  wdog <= wdog + 1'b1;
               end
            end
            ARB_DONE: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_offchip_line_arbiter.sv
// Scoreboard bench for offchip_line_arbiter: stimulus pushes expected
// responses, a monitor pops them on every done pulse, and a port checker
// watches enable exclusivity, BUSY stability and the turnaround gap.
module tb_offchip_line_arbiter;

   localparam int DW = 128;

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      logic          chk_data;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          ic_req, dc_req, dc_we;
   logic [31:0]   ic_addr, dc_addr;
   logic [DW-1:0] dc_wdata;
   logic          ic_done, ic_err, dc_done, dc_err;
   logic [DW-1:0] ic_rdata, dc_rdata;
   logic [31:0]   mem_addr;
   logic          mem_read_en, mem_write_en;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ready;

   int n_chk = 0, n_err = 0, n_done = 0, cyc = 0;
   exp_t q[$];

   // responder controls
   int            lat = 4;
   logic          resp_on = 1'b1;
   logic          fixed_pat = 1'b0;
   logic [DW-1:0] rd_pat = '0;

   // snapshot of the port on the first enabled cycle of a transaction
   logic [31:0]   snap_addr;
   logic [DW-1:0] snap_wdata;
   logic          snap_rd, snap_wr;

   offchip_line_arbiter #(.LINE_BYTES(16), .ADDR_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata), .ic_err(ic_err),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_done(dc_done), .dc_rdata(dc_rdata), .dc_err(dc_err),
      .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic id, input logic [DW-1:0] d, input logic cd, input logic e);
      exp_t x;
      x.id = id; x.data = d; x.chk_data = cd; x.err = e;
      q.push_back(x);
   endtask

   // Downstream port: ready for one cycle after lat enabled cycles.
   initial begin
      int rcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if ((mem_read_en || mem_write_en) && resp_on) begin
            rcnt++;
            if (rcnt == lat) begin
               mem_ready = 1'b1;
               mem_rdata = fixed_pat ? rd_pat : {4{mem_addr}};
            end else begin
               mem_ready = 1'b0;
            end
         end else begin
            rcnt = 0;
            mem_ready = 1'b0;
         end
      end
   end

   // Monitor: every done pulse consumes one scoreboard entry.
   initial begin
      exp_t e;
      logic id;
      forever begin
         @(negedge clk);
         if (rst && (ic_done || dc_done)) begin
            n_done++;
            chk("single_done", {127'b0, ic_done && dc_done}, '0);
            if (q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_done: got ic_done=%0b dc_done=%0b expected none", ic_done, dc_done);
            end else begin
               e = q.pop_front();
               id = dc_done;
               chk("done_id", {127'b0, id}, {127'b0, e.id});
               if (e.chk_data) chk("rdata", id ? dc_rdata : ic_rdata, e.data);
               chk("err", {127'b0, id ? dc_err : ic_err}, {127'b0, e.err});
            end
         end
      end
   end

   // Port checker: exclusive enables, stable command in BUSY, >=2 idle cycles between.
   initial begin
      logic          prev_en = 1'b0, prev_rd = 1'b0;
      logic [31:0]   prev_addr = '0;
      logic [DW-1:0] prev_wdata = '0;
      int            low_run = 100;
      forever begin
         @(negedge clk);
         if (mem_read_en || mem_write_en) begin
            chk("en_exclusive", {127'b0, mem_read_en && mem_write_en}, '0);
            if (!prev_en) chk("turnaround_ge2", {127'b0, low_run >= 2}, {127'b0, 1'b1});
            else begin
               chk("busy_addr_stable", {96'b0, mem_addr}, {96'b0, prev_addr});
               chk("busy_wdata_stable", mem_wdata, prev_wdata);
               chk("busy_cmd_stable", {127'b0, mem_read_en}, {127'b0, prev_rd});
            end
            low_run = 0;
         end else begin
            low_run++;
         end
         prev_en = mem_read_en || mem_write_en;
         prev_rd = mem_read_en;
         prev_addr = mem_addr;
         prev_wdata = mem_wdata;
      end
   end

   // One requester transaction: raise req, wait for its done, drop req.
   task automatic run_txn(input logic id, input logic we, input logic [31:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_d,
                          input logic chk_d, input logic exp_e,
                          output int iss_c, output int rise_c, output int done_c);
      @(negedge clk);
      iss_c = cyc;
      if (id) begin dc_req = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wd; end
      else begin ic_req = 1'b1; ic_addr = addr; end
      push_exp(id, exp_d, chk_d, exp_e);
      rise_c = -1;
      done_c = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rise_c < 0 && (mem_read_en || mem_write_en)) begin
            rise_c = cyc;
            snap_addr = mem_addr; snap_wdata = mem_wdata;
            snap_rd = mem_read_en; snap_wr = mem_write_en;
         end
         if (id ? dc_done : ic_done) begin
            done_c = cyc;
            break;
         end
      end
      chk("txn_completed", {127'b0, done_c >= 0}, {127'b0, 1'b1});
      if (id) dc_req = 1'b0; else ic_req = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Global time bound.
   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish before bound");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      int ic_c, rc, dcn, base;
      ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
      rst = 1'b0;
      #1;
      chk("rst_rd_en", {127'b0, mem_read_en}, '0);
      chk("rst_wr_en", {127'b0, mem_write_en}, '0);
      chk("rst_mem_addr", {96'b0, mem_addr}, '0);
      chk("rst_outputs", {ic_done, dc_done, ic_err, dc_err, ic_rdata | dc_rdata | mem_wdata}, '0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // I-cache fill, unaligned address, 4-cycle downstream latency
      lat = 4; fixed_pat = 1'b1; rd_pat = {16{8'hA5}};
      run_txn(1'b0, 1'b0, 32'h1000_0007, '0, {16{8'hA5}}, 1'b1, 1'b0, ic_c, rc, dcn);
      chk("t1_en_latency", rc - ic_c, 1);
      chk("t1_mem_addr", {96'b0, snap_addr}, {96'b0, 32'h1000_0000});
      chk("t1_cmd", {126'b0, snap_rd, snap_wr}, {126'b0, 2'b10});
      chk("t1_done_latency", dcn - rc, 4);
      fixed_pat = 1'b0;

      // D-cache writeback
      run_txn(1'b1, 1'b1, 32'h2000_0010, 128'h0123456789ABCDEF0123456789ABCDEF, '0, 1'b0, 1'b0, ic_c, rc, dcn);
      chk("t2_cmd", {126'b0, snap_rd, snap_wr}, {126'b0, 2'b01});
      chk("t2_mem_addr", {96'b0, snap_addr}, {96'b0, 32'h2000_0010});
      chk("t2_mem_wdata", snap_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);

      // Both requesting out of reset, held for 3 rounds: DC, IC, DC, IC, DC, IC
      pulse_reset();
      lat = 2;
      @(negedge clk);
      ic_addr = 32'h3000_0004; dc_addr = 32'h4000_000C; dc_we = 1'b0;
      ic_req = 1'b1; dc_req = 1'b1;
      for (int r = 0; r < 3; r++) begin
         push_exp(1'b1, {4{32'h4000_0000}}, 1'b1, 1'b0);
         push_exp(1'b0, {4{32'h3000_0000}}, 1'b1, 1'b0);
      end
      base = n_done;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (n_done >= base + 6) break;
      end
      ic_req = 1'b0; dc_req = 1'b0;
      chk("tie_done_count", n_done - base, 6);
      repeat (4) @(negedge clk);

      // Watchdog: no ready, DC fill keeps previous dc_rdata and flags err
      resp_on = 1'b0;
      run_txn(1'b1, 1'b0, 32'h5000_0020, '0, {4{32'h4000_0000}}, 1'b1, 1'b1, ic_c, rc, dcn);
      chk("timeout_cycles", dcn - rc, 9);
      resp_on = 1'b1;
      lat = 3;
      run_txn(1'b0, 1'b0, 32'h6000_0008, '0, {4{32'h6000_0000}}, 1'b1, 1'b0, ic_c, rc, dcn);
      chk("after_timeout_latency", dcn - rc, 3);

      // Reset in the middle of BUSY
      lat = 30;
      @(negedge clk);
      ic_req = 1'b1; ic_addr = 32'h7000_0000;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", {127'b0, mem_read_en}, {127'b0, 1'b1});
      rst = 1'b0;
      #1;
      ic_req = 1'b0;
      chk("mid_rst_rd_en", {127'b0, mem_read_en}, '0);
      chk("mid_rst_mem_addr", {96'b0, mem_addr}, '0);
      chk("mid_rst_dc_rdata", dc_rdata, '0);
      chk("mid_rst_ic_rdata", ic_rdata, '0);
      chk("mid_rst_flags", {124'b0, ic_done, dc_done, ic_err, dc_err}, '0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      lat = 3;
      run_txn(1'b0, 1'b0, 32'h7000_0000, '0, {4{32'h7000_0000}}, 1'b1, 1'b0, ic_c, rc, dcn);
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
